// File: rtl/eeprom_cmd_seq.sv
// Command sequencer for an RM25C256-style SPI EEPROM (mode 0).
// Launches one opcode/address/data frame per request and returns the read byte.
module eeprom_cmd_seq #(
  parameter int SER_LEN    = 8,
  parameter int ADDR_W     = 16,
  parameter int CSB_HI_CYC = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req,
  input  logic [SER_LEN-1:0] op,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [SER_LEN-1:0] wdata,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [SER_LEN-1:0] rdata,
  output logic               csb,
  output logic [SER_LEN-1:0] inst,
  input  logic               sck,
  output logic               si,
  input  logic               so
);

  localparam int TX_W = 2*SER_LEN + ADDR_W;
  localparam int GW   = $clog2(CSB_HI_CYC + 1);

  typedef enum logic [2:0] {IDLE, ERR, SETUP, SHIFT, TAIL, GAP} state_t;
  state_t state, state_nx;

  logic               sck_q, rise, fall;
  logic [TX_W-1:0]    tx, dec_tx;
  logic [SER_LEN-1:0] rx, op_q;
  logic [5:0]         bit_cnt, n_out, n_tot, dec_out, dec_tot;
  logic               rd_op, dec_rd, dec_ok;
  logic [GW-1:0]      gap_cnt;
  logic               gap_last;

  assign rise     = sck & ~sck_q;
  assign fall     = ~sck & sck_q;
  assign gap_last = (gap_cnt == GW'(CSB_HI_CYC - 1));

  // Frame decode: tx is left-aligned so si always comes from the MSB.
  always_comb begin
    dec_ok  = 1'b1;
    dec_rd  = 1'b0;
    dec_out = 6'(SER_LEN);
    dec_tot = 6'(SER_LEN);
    dec_tx  = {op, {(TX_W-SER_LEN){1'b0}}};
    case (op)
      SER_LEN'(8'h06), SER_LEN'(8'h04), SER_LEN'(8'h60), SER_LEN'(8'hC7),
      SER_LEN'(8'hB9), SER_LEN'(8'hAB), SER_LEN'(8'h79): ;
      SER_LEN'(8'h05): begin
        dec_tot = 6'(2*SER_LEN);
        dec_rd  = 1'b1;
      end
      SER_LEN'(8'h01): begin
        dec_out = 6'(2*SER_LEN);
        dec_tot = 6'(2*SER_LEN);
        dec_tx  = {op, wdata, {ADDR_W{1'b0}}};
      end
      SER_LEN'(8'h03): begin
        dec_out = 6'(SER_LEN + ADDR_W);
        dec_tot = 6'(TX_W);
        dec_tx  = {op, addr, {SER_LEN{1'b0}}};
        dec_rd  = 1'b1;
      end
      SER_LEN'(8'h02): begin
        dec_out = 6'(TX_W);
        dec_tot = 6'(TX_W);
        dec_tx  = {op, addr, wdata};
      end
      // dummy byte is the zero tail of tx, counted as out bits
      SER_LEN'(8'h0B): begin
        dec_out = 6'(TX_W);
        dec_tot = 6'(TX_W + SER_LEN);
        dec_tx  = {op, addr, {SER_LEN{1'b0}}};
        dec_rd  = 1'b1;
      end
      default: dec_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req) state_nx = dec_ok ? SETUP : ERR;
      ERR:     state_nx = IDLE;
      SETUP:   state_nx = SHIFT;
      SHIFT:   if (rise && (bit_cnt + 6'd1 == n_tot)) state_nx = TAIL;
      TAIL:    if (fall) state_nx = GAP;
      GAP:     if (gap_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_q   <= 1'b0;
      tx      <= '0;
      rx      <= '0;
      op_q    <= '0;
      bit_cnt <= '0;
      n_out   <= '0;
      n_tot   <= '0;
      rd_op   <= 1'b0;
      gap_cnt <= '0;
      rdata   <= '0;
    end else begin
      sck_q <= sck;
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (req) begin
            op_q  <= op;
            tx    <= dec_tx;
            n_out <= dec_out;
            n_tot <= dec_tot;
            rd_op <= dec_rd;
          end
        end
        SHIFT: begin
          if (rise) begin
            bit_cnt <= bit_cnt + 6'd1;
            if (bit_cnt >= n_out) rx <= {rx[SER_LEN-2:0], so};
          end
          if (fall && bit_cnt < n_tot) tx <= tx << 1;
        end
        TAIL: gap_cnt <= '0;
        GAP: begin
          gap_cnt <= gap_cnt + GW'(1);
          // load one cycle early so rdata is already valid alongside done
          if (gap_cnt == GW'(CSB_HI_CYC - 2) && rd_op) rdata <= rx;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == ERR) || (state == GAP && gap_last);
    err  = (state == ERR);
    csb  = !(state == SETUP || state == SHIFT || state == TAIL);
    inst = busy ? op_q : '0;
    si   = !csb && (bit_cnt < n_out) && tx[TX_W-1];
  end

endmodule

// File: tb/tb_eeprom_cmd_seq.sv
// Directed bench: SCK generator and EEPROM so model driven from one linear sequence.
module tb_eeprom_cmd_seq;
  logic       clk = 1'b0, reset = 1'b1, req = 1'b0, sck = 1'b0, so = 1'b0;
  logic [7:0] op = '0, wdata = '0;
  logic [15:0] addr = '0;
  logic       busy, done, err, csb, si;
  logic [7:0] rdata, inst;

  int vectors = 0, miscompares = 0;
  int rise_total = 0, hi_run = 0, last_gap = 0, r0;
  logic [39:0] stream;
  logic        got_done, got_err, got_csb;
  logic [7:0]  got_rdata;

  eeprom_cmd_seq dut (
    .clk(clk), .reset(reset), .req(req), .op(op), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata), .csb(csb), .inst(inst),
    .sck(sck), .si(si), .so(so)
  );

  always #5 clk = ~clk;

  always @(posedge sck) if (!csb) rise_total <= rise_total + 1;

  always @(posedge clk) begin
    if (csb) hi_run <= hi_run + 1;
    else begin
      if (hi_run > 0) last_gap <= hi_run;
      hi_run <= 0;
    end
  end

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [7:0] o, input logic [15:0] a, input logic [7:0] w);
    @(negedge clk); op = o; addr = a; wdata = w; req = 1'b1;
    @(negedge clk); req = 1'b0;
    r0 = rise_total;
  endtask

  // n_tot sck pulses; the so model presents resp MSB-first from the fall after rise n_out
  task automatic clock_bits(input int n_out, input int n_tot, input int half,
                            input logic [7:0] resp, input int stop_at);
    stream = '0;
    for (int i = 1; i <= n_tot; i++) begin
      @(negedge clk);
      stream = {stream[38:0], si};
      sck = 1'b1;
      if (i == stop_at) begin
        reset = 1'b1;
        break;
      end
      repeat (half - 1) @(negedge clk);
      @(negedge clk); sck = 1'b0;
      if (i >= n_out && i < n_tot) so = resp[7-(i-n_out)];
      repeat (half - 1) @(negedge clk);
    end
    so = 1'b0;
  endtask

  task automatic wait_done();
    got_done = 1'b0; got_err = 1'b0; got_rdata = '0; got_csb = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done) begin
        got_done = 1'b1; got_err = err; got_rdata = rdata; got_csb = csb;
        break;
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", 40'(busy), 40'd0);
    check("rst_done", 40'(done), 40'd0);
    check("rst_err", 40'(err), 40'd0);
    check("rst_rdata", 40'(rdata), 40'd0);
    check("rst_csb", 40'(csb), 40'd1);
    check("rst_inst", 40'(inst), 40'd0);
    check("rst_si", 40'(si), 40'd0);
    reset = 1'b0;

    // WREN: 8 out bits
    start(8'h06, 16'h0000, 8'h00);
    check("wren_csb", 40'(csb), 40'd0);
    check("wren_busy", 40'(busy), 40'd1);
    check("wren_inst", 40'(inst), 40'h06);
    clock_bits(8, 8, 3, 8'h00, 0);
    wait_done();
    check("wren_done", 40'(got_done), 40'd1);
    check("wren_err", 40'(got_err), 40'd0);
    check("wren_rdata", 40'(got_rdata), 40'h00);
    check("wren_si", 40'(stream[7:0]), 40'h06);
    check("wren_rises", 40'(rise_total - r0), 40'd8);
    @(negedge clk);
    check("idle_busy", 40'(busy), 40'd0);
    check("idle_inst", 40'(inst), 40'd0);

    // READ 0x1234 -> A5, with a stray req while busy
    start(8'h03, 16'h1234, 8'h00);
    @(negedge clk); op = 8'h06; req = 1'b1;
    @(negedge clk); req = 1'b0;
    check("read_ign_inst", 40'(inst), 40'h03);
    clock_bits(24, 32, 3, 8'hA5, 0);
    wait_done();
    check("read_done", 40'(got_done), 40'd1);
    check("read_err", 40'(got_err), 40'd0);
    check("read_rdata", 40'(got_rdata), 40'hA5);
    check("read_si", 40'(stream[31:0]), 40'h03123400);
    check("read_rises", 40'(rise_total - r0), 40'd32);
    check("read_done_csb", 40'(got_csb), 40'd1);

    // WRITE 0x7FFF <- 3C
    start(8'h02, 16'h7FFF, 8'h3C);
    clock_bits(32, 32, 3, 8'h00, 0);
    wait_done();
    check("write_done", 40'(got_done), 40'd1);
    check("write_rdata", 40'(got_rdata), 40'hA5);
    check("write_si", 40'(stream[31:0]), 40'h027FFF3C);
    check("write_rises", 40'(rise_total - r0), 40'd32);

    // FAST_READ 0x0100 -> 5A with one-cycle sck phases
    start(8'h0B, 16'h0100, 8'h00);
    clock_bits(32, 40, 1, 8'h5A, 0);
    wait_done();
    check("fread_done", 40'(got_done), 40'd1);
    check("fread_rdata", 40'(got_rdata), 40'h5A);
    check("fread_si", stream, 40'h0B01000000);
    check("fread_rises", 40'(rise_total - r0), 40'd40);

    // unsupported opcode
    @(negedge clk); op = 8'hFF; req = 1'b1;
    @(negedge clk); req = 1'b0;
    check("bad_done", 40'(done), 40'd1);
    check("bad_err", 40'(err), 40'd1);
    check("bad_csb", 40'(csb), 40'd1);
    @(negedge clk);
    check("bad_done_end", 40'(done), 40'd0);
    check("bad_busy_end", 40'(busy), 40'd0);
    check("bad_rdata", 40'(rdata), 40'h5A);

    // reset at rise 12 of a READ
    start(8'h03, 16'h1234, 8'h00);
    clock_bits(24, 32, 3, 8'hA5, 12);
    @(negedge clk);
    check("mid_rst_csb", 40'(csb), 40'd1);
    check("mid_rst_busy", 40'(busy), 40'd0);
    check("mid_rst_inst", 40'(inst), 40'd0);
    check("mid_rst_si", 40'(si), 40'd0);
    check("mid_rst_rdata", 40'(rdata), 40'd0);
    reset = 1'b0; sck = 1'b0;
    repeat (2) @(negedge clk);

    // back-to-back RDSR
    start(8'h05, 16'h0000, 8'h00);
    clock_bits(8, 16, 2, 8'h81, 0);
    wait_done();
    check("rdsr1_rdata", 40'(got_rdata), 40'h81);
    start(8'h05, 16'h0000, 8'h00);
    clock_bits(8, 16, 2, 8'h42, 0);
    wait_done();
    check("rdsr2_done", 40'(got_done), 40'd1);
    check("rdsr2_rdata", 40'(got_rdata), 40'h42);
    check("rdsr2_si", 40'(stream[15:0]), 40'h0500);
    check("rdsr2_rises", 40'(rise_total - r0), 40'd16);
    check("csb_gap", 40'(last_gap >= 11), 40'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
